// File: rtl/bram32k_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram32k_reader
//  Description : Sequential BRAM32k read/drain engine with a 2-entry skid FIFO
//                and valid/ready output. Optional macro READER_RELU_EN clamps
//                each signed 8-bit lane to zero before the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram32k_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              en_BRAM32k_rd,
    output logic [ADDR_W-1:0] addr_BRAM32k_rd,
    input  logic [DATA_W-1:0] dout_BRAM32k_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam int         c_LANES    = DATA_W / 8;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remain;
    logic [ADDR_W:0]   r_out_cnt;
    logic              r_inflight;
    logic [DATA_W-1:0] r_mem [0:1];
    logic              r_wr_sel;
    logic              r_rd_sel;
    logic [1:0]        r_occ;
    logic              r_busy;
    logic              r_done;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_credit;
    logic              w_issue;
    logic [DATA_W-1:0] w_push_data;

    assign m_valid  = (r_occ != 2'd0);
    assign w_pop    = m_valid && m_ready;
    assign w_push   = r_inflight;
    // Entries held plus the word still coming back, minus the one leaving now.
    assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_state == c_ST_RUN) && (w_credit < 3'd2);

    assign en_BRAM32k_rd   = w_issue;
    assign addr_BRAM32k_rd = r_ptr;
    assign m_data          = r_mem[r_rd_sel];
    assign m_last          = m_valid && (r_out_cnt == (ADDR_W+1)'(1));
    assign busy            = r_busy;
    assign done            = r_done;

`ifdef READER_RELU_EN
    for (genvar i = 0; i < c_LANES; i++) begin : g_relu_lane
        assign w_push_data[8*i +: 8] = dout_BRAM32k_rd[8*i+7] ? 8'h00 : dout_BRAM32k_rd[8*i +: 8];
    end
`else
    assign w_push_data = dout_BRAM32k_rd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_ptr      <= '0;
            r_remain   <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_occ      <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_mem[r_wr_sel] <= w_push_data;
                r_wr_sel        <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_rd_sel  <= ~r_rd_sel;
                r_out_cnt <= r_out_cnt - (ADDR_W+1)'(1);
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_ptr     <= base;
                            r_remain  <= len;
                            r_out_cnt <= len;
                            r_busy    <= 1'b1;
                            r_state   <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (w_issue) begin
                        r_ptr    <= r_ptr + ADDR_W'(1);
                        r_remain <= r_remain - (ADDR_W+1)'(1);
                        if (r_remain == (ADDR_W+1)'(1)) begin
                            r_state <= c_ST_FLUSH;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    // Last outstanding word leaving means FIFO empty and nothing in flight.
                    if (w_pop && (r_out_cnt == (ADDR_W+1)'(1))) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram32k_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram32k_reader
//  Description : Scoreboard bench for bram32k_reader with a 1-cycle BRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram32k_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base = '0;
    logic [12:0] len = '0;
    logic        en;
    logic [11:0] addr;
    logic [63:0] dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [63:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -10;
    int outstanding = 0;
    bit prev_stall = 1'b0;
    bit len0_mode = 1'b0;
    logic [63:0] held_data;
    logic        held_last;

    logic [63:0] bram [4096];
    logic [64:0] sb [$];
    logic [11:0] addr_q [$];

    bram32k_reader #(.ADDR_W(12), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .en_BRAM32k_rd(en), .addr_BRAM32k_rd(addr), .dout_BRAM32k_rd(dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (en) dout <= bram[addr];

    function automatic logic [63:0] exp_word(input logic [63:0] w);
        logic [63:0] r;
        r = w;
`ifdef READER_RELU_EN
        for (int k = 0; k < 8; k++) if (w[8*k+7]) r[8*k +: 8] = 8'h00;
`endif
        return r;
    endfunction

    // Output monitor: scoreboard pops, stall stability, read order, credit, done timing.
    always @(negedge clk) begin
        int p;
        logic [64:0] e;
        logic [11:0] ea;
        if (!rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            p = (m_valid && m_ready) ? 1 : 0;
            if (prev_stall && m_valid) begin
                checks++;
                if (m_data !== held_data || m_last !== held_last) begin
                    errors++;
                    $display("FAIL stall_hold data=%h last=%b expected data=%h last=%b", m_data, m_last, held_data, held_last);
                end
            end
            if (en) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read addr=%0d expected no read", addr);
                end else begin
                    ea = addr_q.pop_front();
                    if (addr !== ea) begin
                        errors++;
                        $display("FAIL read_addr addr=%0d expected %0d", addr, ea);
                    end
                end
                checks++;
                if (outstanding - p >= 2) begin
                    errors++;
                    $display("FAIL credit outstanding=%0d pop=%0d expected below 2 when en", outstanding, p);
                end
            end
            if (p == 1) begin
                checks++;
                hs_cyc = cyc;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word data=%h expected none", m_data);
                end else begin
                    e = sb.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("FAIL word data=%h last=%b expected data=%h last=%b", m_data, m_last, e[63:0], e[64]);
                    end
                end
            end
            if (done && !len0_mode) begin
                checks++;
                if (cyc !== hs_cyc + 1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing cyc=%0d busy=%b expected cyc=%0d busy=0", cyc, busy, hs_cyc + 1);
                end
            end
            outstanding = outstanding + (en ? 1 : 0) - p;
            prev_stall  = m_valid && !m_ready;
            held_data   = m_data;
            held_last   = m_last;
        end
    end

    task automatic pulse_start(input logic [11:0] b, input logic [12:0] l);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base = $urandom; len = $urandom;
    endtask

    task automatic start_xfer(input logic [11:0] b, input logic [12:0] l);
        logic [11:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = b + i[11:0];
            sb.push_back({(i == int'(l) - 1), exp_word(bram[a])});
            addr_q.push_back(a);
        end
        pulse_start(b, l);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        m_ready = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout done=0 expected done within %0d cycles", budget);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained words_left=%0d reads_left=%0d expected 0 0", name, sb.size(), addr_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({en, addr, m_valid, m_data, m_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state en=%b addr=%0d valid=%b data=%h last=%b busy=%b done=%b expected all 0",
                     en, addr, m_valid, m_data, m_last, busy, done);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        start_xfer(12'd0, 13'd4);
        @(negedge clk);
        checks++;
        if (en !== 1'b1 || addr !== 12'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_read en=%b addr=%0d busy=%b expected 1 0 1", en, addr, busy);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_early m_valid=%b expected 0", m_valid);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_latency m_valid=%b expected 1", m_valid);
        end
        wait_done(20, 1'b0);
        check_drained("basic");
    endtask

    task automatic test_wrap();
        start_xfer(12'd4094, 13'd4);
        wait_done(20, 1'b0);
        check_drained("wrap");
    endtask

    task automatic test_backpressure();
        start_xfer(12'd100, 13'd5);
        wait_done(200, 1'b1);
        check_drained("backpressure");
        start_xfer(12'd300, 13'd17);
        wait_done(400, 1'b1);
        check_drained("backpressure_long");
    endtask

    task automatic test_len0_and_busy();
        len0_mode = 1'b1;
        pulse_start(12'd5, 13'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0 done=%b en=%b valid=%b busy=%b expected 1 0 0 0", done, en, m_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || en !== 1'b0) begin
            errors++;
            $display("FAIL len0_pulse done=%b en=%b expected 0 0", done, en);
        end
        len0_mode = 1'b0;
        start_xfer(12'd20, 13'd6);
        repeat (2) @(posedge clk);
        pulse_start(12'd0, 13'd1);
        wait_done(40, 1'b0);
        repeat (6) @(posedge clk);
        check_drained("busy_ignore");
    endtask

    task automatic test_reset_mid();
        start_xfer(12'd0, 13'd100);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({en, addr, m_valid, m_data, m_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid en=%b addr=%0d valid=%b data=%h last=%b busy=%b done=%b expected all 0",
                     en, addr, m_valid, m_data, m_last, busy, done);
        end
        sb.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        start_xfer(12'd10, 13'd2);
        wait_done(20, 1'b0);
        repeat (4) @(posedge clk);
        check_drained("after_reset");
    endtask

    task automatic test_relu();
        bram[200] = 64'h807F_FF01_0081_10F0;
`ifdef READER_RELU_EN
        sb.push_back({1'b1, 64'h007F_0001_0000_1000});
`else
        sb.push_back({1'b1, 64'h807F_FF01_0081_10F0});
`endif
        addr_q.push_back(12'd200);
        pulse_start(12'd200, 13'd1);
        wait_done(20, 1'b0);
        check_drained("relu");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) bram[i] = 64'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0_and_busy();
        test_reset_mid();
        test_relu();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t expected completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bram32k_reader.md
# bram32k_reader

Read-side drain engine for the 4096×64 BRAM32k feature-map buffer that the layer-1 PE fills through its write port. After a start pulse it issues sequential reads on a spare BRAM32k port, absorbs the 1-cycle BRAM read latency with a 2-entry buffer, and streams the words out on a valid/ready interface toward the next layer or a debug/readback path. It sits beside the PE in the top level, clocked by the clock-wizard output clock.

## Interface
- ADDR_W, 12, BRAM32k address width (depth 2^ADDR_W words)
- DATA_W, 64, BRAM32k word width (multiple of 8)
- clk  in  1  system clock (clock-wizard output); all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base  in  ADDR_W  first word address, captured on accepted start
- len  in  ADDR_W+1  number of words, 0..4096, captured on accepted start
- en_BRAM32k_rd  out  1  BRAM read enable
- addr_BRAM32k_rd  out  ADDR_W  BRAM read address
- dout_BRAM32k_rd  in  DATA_W  BRAM read data, valid 1 cycle after enable
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  DATA_W  output word
- m_last  out  1  marks final word of a transfer
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final handshake

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: start=1 captures base/len; len=0 -> no reads, done pulses next cycle, stay IDLE; len>0 -> RUN, busy=1.
- RUN: issue read (en=1, addr=current pointer) when occ + inflight − pop < 2, where occ = buffer entries, inflight = read issued last cycle, pop = m_valid && m_ready. Pointer increments per issue, wraps 4095 -> 0 (mod 2^ADDR_W). After len reads issued -> FLUSH.
- FLUSH: no reads; leaves to IDLE when buffer empty and no read in flight; done pulses that cycle, busy drops.
- Returned word is pushed into 2-entry FIFO on the cycle after its enable; FIFO head drives m_data.
- m_last = 1 on the word whose handshake is the len-th of the transfer.
- start while busy ignored; base/len changes while busy ignored.
- Outputs en/addr combinational from state and credit; m_valid/m_data/m_last from FIFO registers.

## Timing
- Reset (async assert, sync-released by clock): state IDLE, en=0, addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, FIFO empty, inflight cleared. Reset mid-transfer aborts; no partial data survives.
- Start sampled at edge E0 -> en=1, addr=base in cycle after E0; m_valid rises after E2 (2-cycle start-to-valid latency).
- With m_ready held 1: one word per cycle, transfer of N words takes N+2 cycles from E0 to final handshake; done at E(N+3) cycle.
- m_valid && !m_ready: m_data, m_last held stable; reads stall once occ+inflight reaches 2; no word lost or duplicated.
- Simultaneous push and pop with occ=2 never occurs (credit rule); push and pop with occ=1 keeps occ=1.
- busy rises the cycle after accepted start, falls with done.

## Configuration
- READER_RELU_EN defined: each signed 8-bit lane of the BRAM word is clamped to 0 if negative before entering the FIFO; no added latency.
- Undefined: words pass through unmodified.

## Test plan
- Reset then start, base=0, len=4, BRAM word[i]=i, m_ready=1 -> m_data 0,1,2,3 on consecutive cycles, m_last on 3, m_valid first high 2 cycles after start, done one cycle after last handshake.
- base=4094, len=4 -> reads addr 4094,4095,0,1 in order; data matches those locations.
- len=5, m_ready toggling 1,0,0,1,... random -> exactly 5 words in order, m_data stable during stalls, en never asserted with occ+inflight=2.
- len=0 start -> no en, no m_valid, done pulse next cycle; start while busy -> ignored, transfer unaffected.
- rst_n low mid-transfer of len=100 -> all outputs to reset values immediately; subsequent start base=10,len=2 yields words 10,11 only.
- READER_RELU_EN defined, word 0x80_7F_FF_01_00_81_10_F0 -> m_data 0x00_7F_00_01_00_00_10_00; undefined -> unchanged.
